// File: rtl/ibus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ibus_arb_pkg
//  Description : Shared types for the two-master instruction-bus arbiter:
//                FSM state encoding, latched request record, master count.
//  Revision    : 1.0  initial release
// ============================================================================
package ibus_arb_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int BUS_ADDR_W  = 32;
  localparam int BUS_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    DRAIN  = 2'd3
  } arb_state_t;

  // One bus request as captured at grant time and replayed to the slave
  typedef struct packed {
    logic                    ren;
    logic                    wen;
    logic [BUS_ADDR_W-1:0]   addr;
    logic [BUS_DATA_W-1:0]   wdata;
    logic [BUS_DATA_W/8-1:0] byte_en;
  } bus_req_t;

endpackage : ibus_arb_pkg
`default_nettype wire

// File: rtl/ibus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ibus_arbiter_if
//  Description : Generic read/write bus with busy-based completion.
//                master modport = side issuing requests,
//                slave modport  = side answering them.
//  Revision    : 1.0  initial release
// ============================================================================
interface ibus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  ren;
  logic                  wen;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     rdata;
  logic                  busy;

  modport master (
    output ren, wen, addr, wdata, byte_en,
    input  rdata, busy
  );

  modport slave (
    input  ren, wen, addr, wdata, byte_en,
    output rdata, busy
  );

endinterface : ibus_arbiter_if
`default_nettype wire

// File: rtl/ibus_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-way winner select. Round-robin on ties
//                (the master that did not win last) unless M0_PRIORITY is set,
//                in which case master 0 wins every tie.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick2
  import ibus_arb_pkg::*;
#(
  parameter int M0_PRIORITY = 0
) (
  input  wire logic [NUM_MASTERS-1:0] i_req,
  input  wire logic                   i_last_grant,
  output logic                        o_valid,
  output logic                        o_grant
);

  assign o_valid = |i_req;

  // Winner index: lone requester wins outright, ties resolved by policy
  always_comb begin
    o_grant = 1'b0;
    if (i_req == 2'b10) begin
      o_grant = 1'b1;
    end else if (i_req == 2'b11) begin
      o_grant = (M0_PRIORITY != 0) ? 1'b0 : ~i_last_grant;
    end
  end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/ibus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ibus_arbiter
//  Description : Two-master to one-slave arbiter for the I$ port. Latches the
//                granted request, holds it on the slave until s.busy drops and
//                returns completion only to the owner. A master that changes
//                its request mid-flight is absorbed through a DRAIN state.
//  Options     : `define IBUS_ARB_PERF_CNT_EN adds grant/drain counters.
//  Revision    : 1.0  initial release
// ============================================================================
module ibus_arbiter
  import ibus_arb_pkg::*;
#(
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int M0_PRIORITY = 0
) (
  input  wire logic       CLK,
  input  wire logic       RST,
  ibus_arbiter_if.slave   m0,
  ibus_arbiter_if.slave   m1,
  ibus_arbiter_if.master  s
`ifdef IBUS_ARB_PERF_CNT_EN
  ,
  output logic [31:0]     grant_cnt0,
  output logic [31:0]     grant_cnt1,
  output logic [31:0]     drain_cnt
`endif
);

  arb_state_t            r_state;
  logic                  r_last_grant;
  bus_req_t              r_req;

  logic [NUM_MASTERS-1:0] w_req;
  logic                  w_valid;
  logic                  w_grant;
  bus_req_t              w_sel_req;
  logic                  w_abandon0;
  logic                  w_abandon1;
  logic                  w_done0;
  logic                  w_done1;

  assign w_req = {m1.ren | m1.wen, m0.ren | m0.wen};

  rr_pick2 #(
    .M0_PRIORITY (M0_PRIORITY)
  ) u_pick (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_grant      (w_grant)
  );

  // Request fields of the winning master, captured on grant
  always_comb begin
    w_sel_req = '0;
    if (w_grant) begin
      w_sel_req.ren     = m1.ren;
      w_sel_req.wen     = m1.wen;
      w_sel_req.addr    = m1.addr;
      w_sel_req.wdata   = m1.wdata;
      w_sel_req.byte_en = m1.byte_en;
    end else begin
      w_sel_req.ren     = m0.ren;
      w_sel_req.wen     = m0.wen;
      w_sel_req.addr    = m0.addr;
      w_sel_req.wdata   = m0.wdata;
      w_sel_req.byte_en = m0.byte_en;
    end
  end

  // A master whose command or address no longer matches the latch has given up
  assign w_abandon0 = (m0.ren != r_req.ren) || (m0.wen != r_req.wen) ||
                      (m0.addr != r_req.addr);
  assign w_abandon1 = (m1.ren != r_req.ren) || (m1.wen != r_req.wen) ||
                      (m1.addr != r_req.addr);

  // Completion is only reported to a still-interested owner
  assign w_done0 = (r_state == GRANT0) && !w_abandon0 && !s.busy;
  assign w_done1 = (r_state == GRANT1) && !w_abandon1 && !s.busy;

  assign m0.busy  = ~w_done0;
  assign m1.busy  = ~w_done1;
  assign m0.rdata = s.rdata;
  assign m1.rdata = s.rdata;

  // ren/wen in the latch are cleared on return to IDLE, so the slave strobes
  // come straight from registers
  assign s.ren     = r_req.ren;
  assign s.wen     = r_req.wen;
  assign s.addr    = r_req.addr;
  assign s.wdata   = r_req.wdata;
  assign s.byte_en = r_req.byte_en;

  // Arbitration FSM: grant from IDLE, hold until slave done or drain abandons
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_req        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_req        <= w_sel_req;
            r_last_grant <= w_grant;
            r_state      <= w_grant ? GRANT1 : GRANT0;
          end
        end
        GRANT0: begin
          if (w_abandon0 && s.busy) begin
            r_state <= DRAIN;
          end else if (!s.busy) begin
            r_state   <= IDLE;
            r_req.ren <= 1'b0;
            r_req.wen <= 1'b0;
          end
        end
        GRANT1: begin
          if (w_abandon1 && s.busy) begin
            r_state <= DRAIN;
          end else if (!s.busy) begin
            r_state   <= IDLE;
            r_req.ren <= 1'b0;
            r_req.wen <= 1'b0;
          end
        end
        DRAIN: begin
          if (!s.busy) begin
            r_state   <= IDLE;
            r_req.ren <= 1'b0;
            r_req.wen <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_req.ren <= 1'b0;
          r_req.wen <= 1'b0;
        end
      endcase
    end
  end

`ifdef IBUS_ARB_PERF_CNT_EN
  logic [31:0] r_grant_cnt0;
  logic [31:0] r_grant_cnt1;
  logic [31:0] r_drain_cnt;
  logic        w_drain_entry;

  assign w_drain_entry = s.busy && (((r_state == GRANT0) && w_abandon0) ||
                                    ((r_state == GRANT1) && w_abandon1));

  // Free-running wrap-around event counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
      r_drain_cnt  <= '0;
    end else begin
      if (w_done0)       r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
      if (w_done1)       r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
      if (w_drain_entry) r_drain_cnt  <= r_drain_cnt + 32'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
  assign drain_cnt  = r_drain_cnt;
`endif

endmodule : ibus_arbiter
`default_nettype wire

// File: tb/tb_ibus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibus_arbiter
//  Description : Directed self-checking bench for ibus_arbiter (round-robin
//                instance plus an M0_PRIORITY=1 instance).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ibus_arbiter;

  logic CLK;
  logic RST;
  int   errors;
  int   checks;

  ibus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  ibus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  ibus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();
  ibus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) pm0_if ();
  ibus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) pm1_if ();
  ibus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ps_if ();

`ifdef IBUS_ARB_PERF_CNT_EN
  logic [31:0] gc0, gc1, dc, pgc0, pgc1, pdc;
`endif

  ibus_arbiter #(.ADDR_W(32), .DATA_W(32), .M0_PRIORITY(0)) u_dut (
    .CLK (CLK), .RST (RST), .m0 (m0_if), .m1 (m1_if), .s (s_if)
`ifdef IBUS_ARB_PERF_CNT_EN
    , .grant_cnt0 (gc0), .grant_cnt1 (gc1), .drain_cnt (dc)
`endif
  );

  ibus_arbiter #(.ADDR_W(32), .DATA_W(32), .M0_PRIORITY(1)) u_dut_p (
    .CLK (CLK), .RST (RST), .m0 (pm0_if), .m1 (pm1_if), .s (ps_if)
`ifdef IBUS_ARB_PERF_CNT_EN
    , .grant_cnt0 (pgc0), .grant_cnt1 (pgc1), .drain_cnt (pdc)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.ren = 0; m0_if.wen = 0; m0_if.addr = 0; m0_if.wdata = 0; m0_if.byte_en = 0;
    m1_if.ren = 0; m1_if.wen = 0; m1_if.addr = 0; m1_if.wdata = 0; m1_if.byte_en = 0;
    s_if.busy = 1; s_if.rdata = 0;
    pm0_if.ren = 0; pm0_if.wen = 0; pm0_if.addr = 0; pm0_if.wdata = 0; pm0_if.byte_en = 0;
    pm1_if.ren = 0; pm1_if.wen = 0; pm1_if.addr = 0; pm1_if.wdata = 0; pm1_if.byte_en = 0;
    ps_if.busy = 1; ps_if.rdata = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    clear_inputs();
    repeat (3) tick();
    @(negedge CLK);
    checks++; if (s_if.ren !== 1'b0) begin errors++; $display("FAIL rst_s_ren: got %b want 0", s_if.ren); end
    checks++; if (s_if.wen !== 1'b0) begin errors++; $display("FAIL rst_s_wen: got %b want 0", s_if.wen); end
    checks++; if (s_if.addr !== 32'h0) begin errors++; $display("FAIL rst_s_addr: got %h want 0", s_if.addr); end
    checks++; if (s_if.wdata !== 32'h0) begin errors++; $display("FAIL rst_s_wdata: got %h want 0", s_if.wdata); end
    checks++; if (s_if.byte_en !== 4'h0) begin errors++; $display("FAIL rst_s_be: got %h want 0", s_if.byte_en); end
    checks++; if (m0_if.busy !== 1'b1) begin errors++; $display("FAIL rst_m0_busy: got %b want 1", m0_if.busy); end
    checks++; if (m1_if.busy !== 1'b1) begin errors++; $display("FAIL rst_m1_busy: got %b want 1", m1_if.busy); end
    tick();
    RST = 0;
  endtask

  // Both request constantly with a zero-wait slave: first tie after reset goes
  // to master 0, then strict alternation, one completion every 2 cycles
  task automatic test_contention();
    logic exp_w;
    m0_if.ren = 1; m0_if.addr = 32'h10;
    m1_if.ren = 1; m1_if.addr = 32'h20;
    s_if.busy = 0; s_if.rdata = 32'hA5A5_0001;
    for (int k = 0; k < 4; k++) begin
      exp_w = k[0];
      @(negedge CLK);
      checks++; if ({m1_if.busy, m0_if.busy} !== 2'b11) begin errors++; $display("FAIL cont_idle_busy[%0d]: got %b want 11", k, {m1_if.busy, m0_if.busy}); end
      tick();
      @(negedge CLK);
      checks++; if ({m1_if.busy, m0_if.busy} !== (exp_w ? 2'b01 : 2'b10)) begin errors++; $display("FAIL cont_grant[%0d]: busy got %b want %b", k, {m1_if.busy, m0_if.busy}, (exp_w ? 2'b01 : 2'b10)); end
      checks++; if (s_if.addr !== (exp_w ? 32'h20 : 32'h10)) begin errors++; $display("FAIL cont_addr[%0d]: got %h want %h", k, s_if.addr, (exp_w ? 32'h20 : 32'h10)); end
      tick();
    end
    m0_if.ren = 0; m1_if.ren = 0;
    s_if.busy = 1;
    tick();
  endtask

  task automatic test_single_read();
    m0_if.ren = 1; m0_if.addr = 32'h100;
    s_if.busy = 1; s_if.rdata = 32'h0;
    @(negedge CLK);
    checks++; if (s_if.ren !== 1'b0) begin errors++; $display("FAIL rd_idle_sren: got %b want 0", s_if.ren); end
    tick();
    @(negedge CLK);
    checks++; if (s_if.ren !== 1'b1) begin errors++; $display("FAIL rd_sren: got %b want 1", s_if.ren); end
    checks++; if (s_if.addr !== 32'h100) begin errors++; $display("FAIL rd_saddr: got %h want 100", s_if.addr); end
    checks++; if ({m1_if.busy, m0_if.busy} !== 2'b11) begin errors++; $display("FAIL rd_wait1_busy: got %b want 11", {m1_if.busy, m0_if.busy}); end
    tick();
    @(negedge CLK);
    checks++; if ({m1_if.busy, m0_if.busy} !== 2'b11) begin errors++; $display("FAIL rd_wait2_busy: got %b want 11", {m1_if.busy, m0_if.busy}); end
    tick();
    s_if.busy = 0; s_if.rdata = 32'hDEADBEEF;
    @(negedge CLK);
    checks++; if (m0_if.busy !== 1'b0) begin errors++; $display("FAIL rd_done_m0busy: got %b want 0", m0_if.busy); end
    checks++; if (m0_if.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", m0_if.rdata); end
    checks++; if (m1_if.busy !== 1'b1) begin errors++; $display("FAIL rd_m1busy: got %b want 1", m1_if.busy); end
    tick();
    m0_if.ren = 0;
    @(negedge CLK);
    checks++; if (m0_if.busy !== 1'b1) begin errors++; $display("FAIL rd_after_m0busy: got %b want 1", m0_if.busy); end
    checks++; if (s_if.ren !== 1'b0) begin errors++; $display("FAIL rd_after_sren: got %b want 0", s_if.ren); end
    s_if.busy = 1;
    tick();
  endtask

  task automatic test_redirect();
    m0_if.ren = 1; m0_if.addr = 32'h200;
    s_if.busy = 1;
    tick();
    @(negedge CLK);
    checks++; if (s_if.addr !== 32'h200) begin errors++; $display("FAIL rdr_grant_addr: got %h want 200", s_if.addr); end
    tick();
    m0_if.addr = 32'h300;
    @(negedge CLK);
    checks++; if (m0_if.busy !== 1'b1) begin errors++; $display("FAIL rdr_abandon_busy: got %b want 1", m0_if.busy); end
    tick();
    @(negedge CLK);
    checks++; if ({s_if.ren, s_if.addr} !== {1'b1, 32'h200}) begin errors++; $display("FAIL rdr_drain_hold: got %b/%h want 1/200", s_if.ren, s_if.addr); end
    checks++; if (m0_if.busy !== 1'b1) begin errors++; $display("FAIL rdr_drain_busy: got %b want 1", m0_if.busy); end
    tick();
    s_if.busy = 0; s_if.rdata = 32'hBAD0BAD0;
    @(negedge CLK);
    checks++; if (m0_if.busy !== 1'b1) begin errors++; $display("FAIL rdr_drain_end_busy: got %b want 1", m0_if.busy); end
    checks++; if (s_if.addr !== 32'h200) begin errors++; $display("FAIL rdr_drain_end_addr: got %h want 200", s_if.addr); end
    tick();
    @(negedge CLK);
    checks++; if (s_if.ren !== 1'b0) begin errors++; $display("FAIL rdr_idle_sren: got %b want 0", s_if.ren); end
    checks++; if (m0_if.busy !== 1'b1) begin errors++; $display("FAIL rdr_idle_busy: got %b want 1", m0_if.busy); end
    tick();
    @(negedge CLK);
    checks++; if (s_if.addr !== 32'h300) begin errors++; $display("FAIL rdr_new_addr: got %h want 300", s_if.addr); end
    checks++; if (m0_if.busy !== 1'b0) begin errors++; $display("FAIL rdr_new_done: got %b want 0", m0_if.busy); end
    tick();
    m0_if.ren = 0;
    s_if.busy = 1;
    tick();
  endtask

  // Abandon in the same cycle the slave finishes: straight back to IDLE
  task automatic test_abandon_complete();
    m1_if.ren = 1; m1_if.addr = 32'h80;
    s_if.busy = 1;
    tick();
    @(negedge CLK);
    checks++; if (s_if.addr !== 32'h80) begin errors++; $display("FAIL abc_grant_addr: got %h want 80", s_if.addr); end
    tick();
    m1_if.addr = 32'h84; s_if.busy = 0;
    @(negedge CLK);
    checks++; if (m1_if.busy !== 1'b1) begin errors++; $display("FAIL abc_no_done: got %b want 1", m1_if.busy); end
    tick();
    @(negedge CLK);
    checks++; if (s_if.ren !== 1'b0) begin errors++; $display("FAIL abc_no_drain: s_ren got %b want 0", s_if.ren); end
    tick();
    @(negedge CLK);
    checks++; if ({s_if.addr, m1_if.busy} !== {32'h84, 1'b0}) begin errors++; $display("FAIL abc_regrant: got %h/%b want 84/0", s_if.addr, m1_if.busy); end
    tick();
    m1_if.ren = 0;
    s_if.busy = 1;
    tick();
  endtask

  task automatic test_write();
    m1_if.wen = 1; m1_if.addr = 32'h40; m1_if.wdata = 32'h12345678; m1_if.byte_en = 4'h3;
    s_if.busy = 1;
    tick();
    @(negedge CLK);
    checks++; if ({s_if.wen, s_if.ren} !== 2'b10) begin errors++; $display("FAIL wr_strobes: got %b want 10", {s_if.wen, s_if.ren}); end
    checks++; if (s_if.addr !== 32'h40) begin errors++; $display("FAIL wr_addr: got %h want 40", s_if.addr); end
    checks++; if (s_if.wdata !== 32'h12345678) begin errors++; $display("FAIL wr_wdata: got %h want 12345678", s_if.wdata); end
    checks++; if (s_if.byte_en !== 4'h3) begin errors++; $display("FAIL wr_be: got %h want 3", s_if.byte_en); end
    checks++; if (m1_if.busy !== 1'b1) begin errors++; $display("FAIL wr_wait_busy: got %b want 1", m1_if.busy); end
    tick();
    s_if.busy = 0;
    @(negedge CLK);
    checks++; if ({m1_if.busy, m0_if.busy} !== 2'b01) begin errors++; $display("FAIL wr_done: busy got %b want 01", {m1_if.busy, m0_if.busy}); end
    tick();
    m1_if.wen = 0; m1_if.wdata = 0; m1_if.byte_en = 0;
    s_if.busy = 1;
    tick();
  endtask

  task automatic test_reset_mid();
    m1_if.ren = 1; m1_if.addr = 32'h50;
    s_if.busy = 1;
    tick();
    @(negedge CLK);
    checks++; if (s_if.ren !== 1'b1) begin errors++; $display("FAIL rm_grant1: s_ren got %b want 1", s_if.ren); end
    tick();
    RST = 1;
    tick();
    RST = 0;
    m0_if.ren = 1; m0_if.addr = 32'h60;
    @(negedge CLK);
    checks++; if ({s_if.ren, s_if.wen} !== 2'b00) begin errors++; $display("FAIL rm_strobes: got %b want 00", {s_if.ren, s_if.wen}); end
    checks++; if (s_if.addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h want 0", s_if.addr); end
    checks++; if ({m1_if.busy, m0_if.busy} !== 2'b11) begin errors++; $display("FAIL rm_busy: got %b want 11", {m1_if.busy, m0_if.busy}); end
    s_if.busy = 0;
    tick();
    @(negedge CLK);
    checks++; if ({m1_if.busy, m0_if.busy} !== 2'b10) begin errors++; $display("FAIL rm_tie_m0: busy got %b want 10", {m1_if.busy, m0_if.busy}); end
    checks++; if (s_if.addr !== 32'h60) begin errors++; $display("FAIL rm_tie_addr: got %h want 60", s_if.addr); end
    tick();
    m0_if.ren = 0;
    tick();
    @(negedge CLK);
    checks++; if ({m1_if.busy, s_if.addr} !== {1'b0, 32'h50}) begin errors++; $display("FAIL rm_m1_next: got %b/%h want 0/50", m1_if.busy, s_if.addr); end
    tick();
    m1_if.ren = 0;
    s_if.busy = 1;
    tick();
  endtask

  task automatic test_m0_priority();
    pm0_if.ren = 1; pm0_if.addr = 32'h700;
    pm1_if.ren = 1; pm1_if.addr = 32'h800;
    ps_if.busy = 0; ps_if.rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      checks++; if ({pm1_if.busy, pm0_if.busy} !== 2'b11) begin errors++; $display("FAIL prio_idle[%0d]: busy got %b want 11", k, {pm1_if.busy, pm0_if.busy}); end
      tick();
      @(negedge CLK);
      checks++; if ({pm1_if.busy, pm0_if.busy} !== 2'b10) begin errors++; $display("FAIL prio_grant[%0d]: busy got %b want 10", k, {pm1_if.busy, pm0_if.busy}); end
      checks++; if (ps_if.addr !== 32'h700) begin errors++; $display("FAIL prio_addr[%0d]: got %h want 700", k, ps_if.addr); end
      tick();
    end
    pm0_if.ren = 0; pm1_if.ren = 0;
    ps_if.busy = 1;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_contention();
    test_single_read();
    test_redirect();
    test_abandon_complete();
    test_write();
    test_reset_mid();
    test_m0_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ibus_arbiter
`default_nettype wire

// File: doc/ibus_arbiter.md
Name: ibus_arbiter

Overview:
- Two-master to one-slave arbiter on the generic bus protocol.
- Shares the single I$ port between the fetch buffer (master 0) and the instruction prefetcher / debug fetch port (master 1).
- Latches each granted request and holds it on the slave until the slave completes (busy low). Completion is forwarded only to the owning master.
- Absorbs requests the master abandons mid-flight (invalidate, PC redirect) through a drain state.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte_en width is DATA_W/8.
- M0_PRIORITY, 0: 0 = round-robin; 1 = master 0 always wins ties.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- m0_ren  in  1  master 0 read request
- m0_wen  in  1  master 0 write request
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_byte_en  in  DATA_W/8  master 0 byte enables
- m0_rdata  out  DATA_W  read data to master 0
- m0_busy  out  1  master 0 busy; low = transaction complete this cycle
- m1_ren, m1_wen, m1_addr, m1_wdata, m1_byte_en, m1_rdata, m1_busy: as master 0, for master 1
- s_ren  out  1  slave read request
- s_wen  out  1  slave write request
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_byte_en  out  DATA_W/8  slave byte enables
- s_rdata  in  DATA_W  slave read data
- s_busy  in  1  slave busy

Behaviour:
- Clocking: one clock CLK; reset RST is synchronous, active-high.
- Request: master N requests when mN_ren | mN_wen. A master holds its request and operands stable until it sees mN_busy = 0.
- States:
  - IDLE: s_ren = s_wen = 0.
  - GRANT0 / GRANT1: slave driven from the latched request register.
  - DRAIN: slave still driven from the latch; no master owns the transaction.
- IDLE:
  - If any request: pick the winner and latch ren, wen, addr, wdata, byte_en into the request register. Next state is GRANT0/GRANT1.
  - Otherwise stay in IDLE.
  - Minimum added latency: 1 cycle.
- Winner selection:
  - M0_PRIORITY = 1: master 0 wins whenever it requests.
  - M0_PRIORITY = 0, both requesting: grant the master that is not last_grant.
  - last_grant resets to 1, so master 0 wins the first tie.
  - last_grant updates on every grant.
- GRANTn:
  - If mN_ren, mN_wen, or mN_addr differ from the latch (abandon or redirect): go to DRAIN. mN_busy stays 1.
  - Else if s_busy = 0: mN_busy = 0 for this cycle; go to IDLE.
  - Else stay in GRANTn.
- DRAIN:
  - Hold slave outputs until s_busy = 0, then go to IDLE.
  - Drained rdata is discarded; both mN_busy = 1.
- Simultaneous abandon and s_busy = 0 in the same cycle: the slave has completed. Go directly to IDLE; no completion is reported; no DRAIN cycle.
- Back-to-back: after completion, the arbiter always passes through IDLE before regranting.
  - Each granted transaction costs at least 2 cycles.
  - Round-robin alternates the masters under constant contention.
- Busy and data outputs:
  - mN_busy = 1 whenever master N is not the completing owner, including when it is not requesting.
  - mN_rdata = s_rdata, broadcast, and valid only when mN_busy = 0.
- s_busy is ignored in IDLE.
- Reset, including mid-transaction:
  - State = IDLE, last_grant = 1, latch cleared.
  - s_ren = s_wen = 0; s_addr, s_wdata, s_byte_en = 0.
  - m0_busy = m1_busy = 1.

Optional Feature:
- Macro: IBUS_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs grant_cnt0, grant_cnt1, drain_cnt (32 bits each).
  - grant_cnt0 / grant_cnt1 increment on each completion reported to master 0 / master 1.
  - drain_cnt increments on each entry into DRAIN.
  - All counters wrap at 2^32 and reset to 0.
- Undefined: ports and logic are absent; arbitration behaviour is identical.

Decomposition:
- Package ibus_arb_pkg:
  - state enum {IDLE, GRANT0, GRANT1, DRAIN};
  - packed struct bus_req_t {ren, wen, addr, wdata, byte_en};
  - localparam NUM_MASTERS = 2.
- Sub-module rr_pick2: combinational winner select taking req[1:0], last_grant, and M0_PRIORITY.

Test Plan:
- Single read: m0_ren, addr 0x100; slave busy for 2 cycles, then rdata 0xDEADBEEF → s_ren rises 1 cycle after the request; m0_busy low for exactly 1 cycle with m0_rdata = 0xDEADBEEF; m1_busy = 1 throughout.
- Contention with round-robin: both masters request continuously; slave has 0-wait (s_busy = 0) → grants alternate 0, 1, 0, 1; each completion is 2 cycles apart.
- Redirect: m0 granted on 0x200; m0_addr changes to 0x300 while s_busy = 1 → DRAIN; s_addr holds 0x200 until s_busy drops; m0_busy stays 1; 0x300 is granted after IDLE.
- Write: m1_wen, addr 0x40, wdata 0x12345678, byte_en 0x3 → slave sees identical values latched; m1 completes on s_busy = 0.
- Reset mid-transaction: RST asserted in GRANT1 → next cycle s_ren = s_wen = 0 and both busy = 1; after RST deasserts with both masters requesting, master 0 wins the tie.
- M0_PRIORITY = 1: both masters request continuously → master 1 is never granted.
